// File: rtl/wb_responder_pkg.sv
// Shared types and helpers for the Wishbone SRAM responder.
//   state_t      : responder FSM states
//   WORD_BYTES   : bytes per bus word
//   in_window()  : 33-bit window check, immune to BASE+size overflow
package wb_responder_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACK,
      ERR
   } state_t;

   localparam int unsigned WORD_BYTES = 4;

   function automatic logic in_window(input logic [31:0] adr,
                                      input logic [31:0] base,
                                      input int unsigned depth);
      logic [32:0] a;
      logic [32:0] lo;
      logic [32:0] hi;
      a  = {1'b0, adr};
      lo = {1'b0, base};
      hi = lo + (33'(depth) * 33'(WORD_BYTES));
      return (a >= lo) && (a < hi);
   endfunction

endpackage

// File: rtl/wishbone_interface.sv
// Wishbone B4 classic bus bundle.
//   slave modport : cyc/stb/we/adr/sel/dat_mosi in, dat_miso/ack/err out
//   master modport: mirror image
interface wishbone_interface;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic [31:0] dat_mosi;
   logic [31:0] dat_miso;
   logic        ack;
   logic        err;

   modport slave  (input  cyc, stb, we, adr, sel, dat_mosi,
                   output dat_miso, ack, err);
   modport master (output cyc, stb, we, adr, sel, dat_mosi,
                   input  dat_miso, ack, err);
endinterface

// File: rtl/wb_bytemask_ram.sv
// Single-port synchronous SRAM, 32-bit words, per-byte write enables,
// registered read data (read-before-write on the same address). No reset.
//   clk     : clock
//   i_en    : access enable (read always performed, writes gated by i_be)
//   i_be    : byte write enables
//   i_addr  : word index
//   i_wdata : write data
//   o_rdata : word read on the last enabled edge
module wb_bytemask_ram
   import wb_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic                           i_en,
   input  logic [WORD_BYTES-1:0]          i_be,
   input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
   input  logic [31:0]                    i_wdata,
   output logic [31:0]                    o_rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (i_en) begin
         for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if (i_be[i]) begin
               r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
         end
         o_rdata <= r_mem[i_addr];
      end
   end

endmodule

// File: rtl/wb_sram_responder.sv
// Wishbone classic slave backed by a byte-writable SRAM, with programmable
// wait states, ERR on out-of-window accesses and access/error statistics.
//   clk, rst     : clock, asynchronous active-high reset
//   wb           : Wishbone slave port
//   access_count : ACKed accesses (wraps)
//   err_count    : ERR responses (saturates at 255)
//   busy         : FSM not in IDLE
module wb_sram_responder
   import wb_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   wishbone_interface.slave        wb,
   output logic [15:0]             access_count,
   output logic [7:0]              err_count,
   output logic                    busy
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t          r_state;
   logic [3:0]      r_wait_cnt;
   logic            r_we;
   logic [AW-1:0]   r_idx;
   logic [3:0]      r_sel;
   logic [31:0]     r_wdata;
   logic            r_ack;
   logic            r_err;
   logic [15:0]     r_access_count;
   logic [7:0]      r_err_count;

   logic            w_req;
   logic            w_in_range;
   logic [AW-1:0]   w_idx_live;
   logic            w_use_live;
   logic            w_enter_ack;
   logic [AW-1:0]   w_ram_idx;
   logic [3:0]      w_ram_be;
   logic [31:0]     w_ram_wdata;
   logic [31:0]     w_ram_rdata;

   assign w_req      = wb.cyc & wb.stb;
   assign w_in_range = in_window(wb.adr, BASE_ADDR, DEPTH_WORDS);
   assign w_idx_live = AW'((wb.adr - BASE_ADDR) >> 2);

   // The RAM read is registered, so the access is issued on the edge that
   // enters ACK; with zero wait states that edge is the request-sampling edge,
   // so the live bus fields feed the RAM instead of the latched copies.
   always_comb begin
      w_use_live  = 1'b0;
      w_enter_ack = 1'b0;
      case (r_state)
         IDLE: begin
            w_use_live  = 1'b1;
            w_enter_ack = w_req & w_in_range & (WAIT_STATES == 0);
         end
         WAIT:    w_enter_ack = w_req & (r_wait_cnt == '0);
         ACK:     w_enter_ack = 1'b0;
         ERR:     w_enter_ack = 1'b0;
      endcase
   end

   assign w_ram_idx   = w_use_live ? w_idx_live : r_idx;
   assign w_ram_wdata = w_use_live ? wb.dat_mosi : r_wdata;
   assign w_ram_be    = w_use_live ? ({4{wb.we}} & wb.sel) : ({4{r_we}} & r_sel);

   wb_bytemask_ram #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_ram (
      .clk     (clk),
      .i_en    (w_enter_ack),
      .i_be    (w_ram_be),
      .i_addr  (w_ram_idx),
      .i_wdata (w_ram_wdata),
      .o_rdata (w_ram_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= IDLE;
         r_wait_cnt     <= '0;
         r_we           <= 1'b0;
         r_idx          <= '0;
         r_sel          <= '0;
         r_wdata        <= '0;
         r_ack          <= 1'b0;
         r_err          <= 1'b0;
         r_access_count <= '0;
         r_err_count    <= '0;
      end else begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_we    <= wb.we;
                  r_idx   <= w_idx_live;
                  r_sel   <= wb.sel;
                  r_wdata <= wb.dat_mosi;
                  if (!w_in_range) begin
                     r_state <= ERR;
                     r_err   <= 1'b1;
                     if (r_err_count != 8'hFF) begin
                        r_err_count <= r_err_count + 8'd1;
                     end
                  end else if (WAIT_STATES == 0) begin
                     r_state        <= ACK;
                     r_ack          <= 1'b1;
                     r_access_count <= r_access_count + 16'd1;
                  end else begin
                     r_state    <= WAIT;
                     r_wait_cnt <= WAIT_INIT;
                  end
               end
            end
            WAIT: begin
               if (!w_req) begin
                  r_state <= IDLE;
               end else if (r_wait_cnt == '0) begin
                  r_state        <= ACK;
                  r_ack          <= 1'b1;
                  r_access_count <= r_access_count + 16'd1;
               end else begin
                  r_wait_cnt <= r_wait_cnt - 4'd1;
               end
            end
            ACK: r_state <= IDLE;
            ERR: r_state <= IDLE;
         endcase
      end
   end

   // Read data is only presented during a read ACK; otherwise the bus is 0.
   assign wb.dat_miso   = (r_ack && !r_we) ? w_ram_rdata : '0;
   assign wb.ack        = r_ack;
   assign wb.err        = r_err;
   assign access_count  = r_access_count;
   assign err_count     = r_err_count;
   assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_wb_sram_responder.sv
// Self-checking bench for wb_sram_responder: two instances (2 wait states
// at base 0 / 1024 words, and 0 wait states at base 0x100 / 16 words).
module tb_wb_sram_responder;

   localparam int WS_A = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wishbone_interface wbm();
   wishbone_interface wbz();

   logic [15:0] acc_a, acc_z;
   logic [7:0]  errc_a, errc_z;
   logic        busy_a, busy_z;

   wb_sram_responder #(
      .BASE_ADDR   (32'h0000_0000),
      .DEPTH_WORDS (1024),
      .WAIT_STATES (WS_A)
   ) u_dut_a (
      .clk          (clk),
      .rst          (rst),
      .wb           (wbm),
      .access_count (acc_a),
      .err_count    (errc_a),
      .busy         (busy_a)
   );

   wb_sram_responder #(
      .BASE_ADDR   (32'h0000_0100),
      .DEPTH_WORDS (16),
      .WAIT_STATES (0)
   ) u_dut_z (
      .clk          (clk),
      .rst          (rst),
      .wb           (wbz),
      .access_count (acc_z),
      .err_count    (errc_z),
      .busy         (busy_z)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      string       nm;
      bit          is_err;
      bit          chk_data;
      logic [31:0] data;
   } exp_t;

   exp_t sb_a[$];
   exp_t sb_z[$];

   // Response monitors: pop the expectation for every ack/err seen.
   always @(negedge clk) begin
      exp_t e;
      chk("a_ack_err_excl", 32'(wbm.ack & wbm.err), 32'd0);
      if (!wbm.ack) chk("a_miso_zero", wbm.dat_miso, 32'd0);
      if (wbm.ack || wbm.err) begin
         if (sb_a.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL a_unexpected_resp: got ack=%0b err=%0b expected none", wbm.ack, wbm.err);
         end else begin
            e = sb_a.pop_front();
            chk({e.nm, "_err"}, 32'(wbm.err), 32'(e.is_err));
            if (e.chk_data) chk({e.nm, "_data"}, wbm.dat_miso, e.data);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      chk("z_ack_err_excl", 32'(wbz.ack & wbz.err), 32'd0);
      if (!wbz.ack) chk("z_miso_zero", wbz.dat_miso, 32'd0);
      if (wbz.ack || wbz.err) begin
         if (sb_z.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL z_unexpected_resp: got ack=%0b err=%0b expected none", wbz.ack, wbz.err);
         end else begin
            e = sb_z.pop_front();
            chk({e.nm, "_err"}, 32'(wbz.err), 32'(e.is_err));
            if (e.chk_data) chk({e.nm, "_data"}, wbz.dat_miso, e.data);
         end
      end
   end

   // Single classic access on instance A, latency checked against WS_A.
   task automatic acc_a_t(input string nm, input bit we, input logic [31:0] adr,
                          input logic [3:0] sel, input logic [31:0] wd,
                          input bit exp_err, input logic [31:0] exp_rd);
      exp_t e;
      int   n;
      e.nm = nm; e.is_err = exp_err; e.chk_data = !we && !exp_err; e.data = exp_rd;
      sb_a.push_back(e);
      @(negedge clk);
      wbm.cyc = 1'b1; wbm.stb = 1'b1; wbm.we = we;
      wbm.adr = adr; wbm.sel = sel; wbm.dat_mosi = wd;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(wbm.ack || wbm.err) && n < 40);
      chk({nm, "_latency"}, 32'(n), exp_err ? 32'd1 : 32'(WS_A + 1));
      wbm.cyc = 1'b0; wbm.stb = 1'b0;
      @(negedge clk);
      chk({nm, "_one_cycle"}, {29'd0, wbm.ack, wbm.err, busy_a}, 32'd0);
   endtask

   // Instance Z: cyc/stb held for four accesses; address advanced in each ACK/ERR cycle.
   task automatic z_burst(input bit we, input logic [31:0] adrs[4],
                          input logic [31:0] dats[4], input bit errs[4]);
      exp_t e;
      int   n, t, last;
      t = 0; last = 0;
      @(negedge clk);
      wbz.cyc = 1'b1; wbz.stb = 1'b1; wbz.we = we; wbz.sel = 4'hF;
      for (int k = 0; k < 4; k++) begin
         e.nm = $sformatf("z_%s%0d", we ? "wr" : "rd", k);
         e.is_err = errs[k]; e.chk_data = !we && !errs[k]; e.data = dats[k];
         sb_z.push_back(e);
         wbz.adr = adrs[k]; wbz.dat_mosi = dats[k];
         n = 0;
         do begin
            @(negedge clk);
            t++; n++;
         end while (!(wbz.ack || wbz.err) && n < 10);
         if (k == 0) chk("z_first_latency", 32'(n), 32'd1);
         else        chk("z_spacing", 32'(t - last), 32'd2);
         last = t;
      end
      wbz.cyc = 1'b0; wbz.stb = 1'b0;
      @(negedge clk);
   endtask

   typedef struct {
      string       nm;
      bit          we;
      logic [31:0] adr;
      logic [3:0]  sel;
      logic [31:0] wd;
      bit          exp_err;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vt[13];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_ok, n_e, pre;
      logic [31:0] za[4], zd[4], zra[4], zrd[4];
      bit ze[4], zre[4];

      vt[0]  = '{"wr10",       1'b1, 32'h10,       4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
      vt[1]  = '{"rd10",       1'b0, 32'h10,       4'hF, 32'h0,        1'b0, 32'hDEADBEEF};
      vt[2]  = '{"wr20",       1'b1, 32'h20,       4'hF, 32'h11223344, 1'b0, 32'h0};
      vt[3]  = '{"wr22_bytes", 1'b1, 32'h22,       4'h5, 32'hAABBCCDD, 1'b0, 32'h0};
      vt[4]  = '{"rd20",       1'b0, 32'h20,       4'hF, 32'h0,        1'b0, 32'h11BB33DD};
      vt[5]  = '{"wr24",       1'b1, 32'h24,       4'hF, 32'h0F0F0F0F, 1'b0, 32'h0};
      vt[6]  = '{"wr24_sel0",  1'b1, 32'h24,       4'h0, 32'h12345678, 1'b0, 32'h0};
      vt[7]  = '{"rd24",       1'b0, 32'h24,       4'hF, 32'h0,        1'b0, 32'h0F0F0F0F};
      vt[8]  = '{"rd1000_oob", 1'b0, 32'h1000,     4'hF, 32'h0,        1'b1, 32'h0};
      vt[9]  = '{"wrFFC",      1'b1, 32'hFFC,      4'hF, 32'hCAFEF00D, 1'b0, 32'h0};
      vt[10] = '{"rdFFF",      1'b0, 32'hFFF,      4'h0, 32'h0,        1'b0, 32'hCAFEF00D};
      vt[11] = '{"wr_top_oob", 1'b1, 32'hFFFFFFFC, 4'hF, 32'h55555555, 1'b1, 32'h0};
      vt[12] = '{"rd10_sel0",  1'b0, 32'h10,       4'h0, 32'h0,        1'b0, 32'hDEADBEEF};

      rst = 1'b1;
      wbm.cyc = 1'b0; wbm.stb = 1'b0; wbm.we = 1'b0; wbm.adr = '0; wbm.sel = '0; wbm.dat_mosi = '0;
      wbz.cyc = 1'b0; wbz.stb = 1'b0; wbz.we = 1'b0; wbz.adr = '0; wbz.sel = '0; wbz.dat_mosi = '0;
      repeat (2) @(negedge clk);
      chk("rst_ack",   32'(wbm.ack), 32'd0);
      chk("rst_err",   32'(wbm.err), 32'd0);
      chk("rst_miso",  wbm.dat_miso, 32'd0);
      chk("rst_busy",  32'(busy_a),  32'd0);
      chk("rst_acc",   32'(acc_a),   32'd0);
      chk("rst_errc",  32'(errc_a),  32'd0);
      rst = 1'b0;

      n_ok = 0; n_e = 0;
      foreach (vt[i]) begin
         acc_a_t(vt[i].nm, vt[i].we, vt[i].adr, vt[i].sel, vt[i].wd, vt[i].exp_err, vt[i].exp_rd);
         if (vt[i].exp_err) n_e++;
         else               n_ok++;
      end
      chk("table_acc_count", 32'(acc_a),  32'(n_ok));
      chk("table_err_count", 32'(errc_a), 32'(n_e));

      // err_count saturation: reach 255, then keep going past it.
      for (int i = 0; i < 255 - n_e; i++) acc_a_t("sat_oob", 1'b0, 32'h2000, 4'hF, 32'h0, 1'b1, 32'h0);
      chk("errc_at_255", 32'(errc_a), 32'd255);
      for (int i = 0; i < 256 - (255 - n_e); i++) acc_a_t("sat_oob", 1'b0, 32'h4000_0000, 4'hF, 32'h0, 1'b1, 32'h0);
      chk("errc_saturated", 32'(errc_a), 32'd255);
      chk("acc_unchanged_by_err", 32'(acc_a), 32'(n_ok));

      // Abort in WAIT: cyc dropped one edge before ACK would be entered.
      acc_a_t("wr40", 1'b1, 32'h40, 4'hF, 32'h00000077, 1'b0, 32'h0);
      pre = int'(acc_a);
      @(negedge clk);
      wbm.cyc = 1'b1; wbm.stb = 1'b1; wbm.we = 1'b1; wbm.adr = 32'h40; wbm.sel = 4'hF; wbm.dat_mosi = 32'h5;
      @(negedge clk);
      chk("abort_busy_wait", 32'(busy_a), 32'd1);
      @(negedge clk);
      wbm.cyc = 1'b0;
      @(negedge clk);
      chk("abort_busy_idle", 32'(busy_a), 32'd0);
      repeat (4) @(negedge clk);
      wbm.stb = 1'b0;
      chk("abort_no_count", 32'(acc_a), 32'(pre));
      acc_a_t("rd40_after_abort", 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, 32'h00000077);

      // Asynchronous reset while in WAIT.
      @(negedge clk);
      wbm.cyc = 1'b1; wbm.stb = 1'b1; wbm.we = 1'b0; wbm.adr = 32'h10; wbm.sel = 4'hF;
      @(negedge clk);
      chk("arst_pre_busy", 32'(busy_a), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("arst_busy", 32'(busy_a), 32'd0);
      chk("arst_ack_err", {30'd0, wbm.ack, wbm.err}, 32'd0);
      chk("arst_acc", 32'(acc_a), 32'd0);
      chk("arst_errc", 32'(errc_a), 32'd0);
      wbm.cyc = 1'b0; wbm.stb = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      acc_a_t("post_rst_rd10", 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF);
      chk("post_rst_acc", 32'(acc_a), 32'd1);

      // Instance Z: back-to-back writes, reads, and window edges.
      za = '{32'h100, 32'h104, 32'h108, 32'h13C};
      zd = '{32'hA0A0A0A0, 32'h12345678, 32'hFEDCBA98, 32'h0BADF00D};
      ze = '{1'b0, 1'b0, 1'b0, 1'b0};
      z_burst(1'b1, za, zd, ze);
      z_burst(1'b0, za, zd, ze);
      zra = '{32'hFC, 32'h13F, 32'h140, 32'h101};
      zrd = '{32'h0, 32'h0BADF00D, 32'h0, 32'hA0A0A0A0};
      zre = '{1'b1, 1'b0, 1'b1, 1'b0};
      z_burst(1'b0, zra, zrd, zre);
      chk("z_acc_count", 32'(acc_z), 32'd10);
      chk("z_err_count", 32'(errc_z), 32'd2);
      chk("z_busy_end", 32'(busy_z), 32'd0);

      repeat (3) @(negedge clk);
      chk("a_sb_drained", 32'(sb_a.size()), 32'd0);
      chk("z_sb_drained", 32'(sb_z.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_sram_responder.md
Name: wb_sram_responder

Overview:
- Wishbone classic (B4, non-pipelined) slave that answers the CPU's data and fetch master ports.
- Backed by a byte-writable on-chip SRAM.
- Inserts a programmable number of wait states, so the pipeline's memory-stage stall path is exercised.
- Reports out-of-window accesses with ERR and keeps access/error statistics for SoC debug.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0 of the window.
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 2.
- WAIT_STATES, 0, extra cycles inserted before ACK; range 0..15.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- wb  modport  wishbone_interface.slave  bus; fields used:
  - cyc, stb, we (inputs, 1 bit each)
  - adr (input, 32), sel (input, 4), dat_mosi (input, 32)
  - dat_miso (output, 32), ack (output, 1), err (output, 1)
- access_count  output  16  completed (ACKed) accesses; wraps
- err_count  output  8  ERR responses; saturates at 255
- busy  output  1  high whenever the FSM state is not IDLE

Behaviour:
- Reset (async):
  - ack=0, err=0, dat_miso=0, busy=0.
  - access_count=0, err_count=0, state=IDLE, wait counter=0.
  - SRAM contents are not reset.
- Address decode:
  - in_range = (adr >= BASE_ADDR) && (adr < BASE_ADDR + 4*DEPTH_WORDS), using 33-bit comparison so there is no overflow.
  - Word index = (adr - BASE_ADDR) >> 2, truncated to clog2(DEPTH_WORDS) bits.
  - adr[1:0] is ignored.
- States: IDLE, WAIT, ACK, ERR (registered outputs only; no combinational path from inputs to ack/err).
- IDLE:
  - cyc&stb & !in_range -> ERR.
  - cyc&stb & in_range & WAIT_STATES==0 -> ACK.
  - cyc&stb & in_range & WAIT_STATES>0 -> WAIT, with wait counter loaded to WAIT_STATES-1.
  - Request fields (we, word index, sel, dat_mosi) are latched on that edge.
- WAIT:
  - If cyc or stb is low: abort to IDLE; no memory access, no ack.
  - Else if counter==0: go to ACK.
  - Else decrement the counter.
- Entering ACK (same edge):
  - Write: for each i with latched sel[i]=1, SRAM byte i <= dat_mosi[8i+7:8i]. sel=4'b0000 still ACKs and changes nothing.
  - Read: dat_miso <= full SRAM word; sel is ignored for reads.
  - ack=1 for exactly one cycle; access_count increments by 1, 0xFFFF -> 0x0000.
- ACK -> IDLE unconditionally. The request visible during the ACK cycle is the one being acknowledged and is NOT resampled.
- Latency and throughput:
  - Request first sampled at edge N; ack is high in the cycle after edge N+WAIT_STATES.
  - Back-to-back throughput is one access per WAIT_STATES+2 cycles.
- ERR:
  - err=1 for exactly one cycle, dat_miso=0, no memory access.
  - err_count increments unless already 255.
  - Next state IDLE.
- dat_miso is 0 in every cycle where ack=0.
- ack and err are never high together.
- busy = (state != IDLE).
- Asynchronous reset in WAIT or ACK: outputs drop immediately. A write is committed only if its ACK-entry edge preceded reset.

Decomposition:
- Package wb_responder_pkg:
  - state_t enum {IDLE, WAIT, ACK, ERR}.
  - Function in_window(adr, base, depth).
  - Constant WORD_BYTES=4.
- One sub-module, wb_bytemask_ram:
  - Synchronous single-port RAM with 4 byte write-enables and registered read data.
  - Parameter DEPTH_WORDS; no reset.
  - Instantiated once. Its read is issued on the ACK-entry edge, so the responder must account for the registered read (present the index one edge earlier, or capture combinationally from the latched index).

Test Plan:
- WAIT_STATES=2, BASE=0: write 0xDEADBEEF to 0x10 with sel=4'hF, then read 0x10 -> each ack appears 3 cycles after stb rises; read dat_miso=0xDEADBEEF; access_count=2.
- Byte select: write 0x11223344 to 0x20, then write 0xAABBCCDD with sel=4'b0101, read -> 0x11BB33DD.
- Out of range, DEPTH=1024: read 0x1000 -> err=1 for one cycle, ack=0, dat_miso=0, err_count=1. 256 further bad accesses -> err_count stays 255.
- Abort: WAIT_STATES=3, write 0x5 to 0x40, drop cyc after 2 cycles -> no ack, busy returns to 0; read 0x40 returns its prior value.
- Back-to-back, WAIT_STATES=0: stb held high for 4 reads -> 4 acks spaced 2 cycles apart, each with the correct word; access_count 0xFFFE +4 -> 0x0002.
- Async reset asserted mid-cycle in WAIT -> ack, err, busy and both counters go to 0 before the next edge; the first access after reset completes with normal latency.
